// File: rtl/bist_prng_multi.sv
// Multi-channel Galois LFSR pattern generator for BIST, with a bypass mode
// that forwards external words through the same output stage.
//
// Ports
//   clk_i, rstn_i           clock, asynchronous active-low reset
//   start_i, bypass_i       run launch / bypass-mode select
//   valid_i, ready_o        bypass input handshake
//   seed_i                  run seed, or bypass data word
//   poly_i                  Galois tap mask (0 selects DEFAULT_POLY)
//   length_i                words per run, 0 = unbounded
//   stop_en_i, stop_code_i  terminate when channel 0 emits stop_code_i
//   ready_i, valid_o        output handshake
//   data_o                  channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   busy_o, done_o          SEED/RUN and DONE status
//   count_o                 completed transfers in the current run

// One LFSR channel: load has priority over step.
module bist_prng_lane #(
  parameter int W = 64
) (
  input  logic         clk_i,
  input  logic         rstn_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         step_i,
  input  logic [W-1:0] poly_i,
  output logic [W-1:0] lfsr_o
);
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)      lfsr_o <= '0;
    else if (load_i)  lfsr_o <= load_val_i;
    else if (step_i)  lfsr_o <= (lfsr_o >> 1) ^ (lfsr_o[0] ? poly_i : '0);
  end
endmodule

module bist_prng_multi #(
  parameter int          DATA_WIDTH   = 64,
  parameter int          NUM_CH       = 4,
  parameter int          CNT_WIDTH    = 16,
  parameter logic [63:0] DEFAULT_POLY = 64'hD800_0000_0000_0000
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         start_i,
  input  logic                         bypass_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [DATA_WIDTH-1:0]        seed_i,
  input  logic [DATA_WIDTH-1:0]        poly_i,
  input  logic [CNT_WIDTH-1:0]         length_i,
  input  logic                         stop_en_i,
  input  logic [DATA_WIDTH-1:0]        stop_code_i,
  input  logic                         ready_i,
  output logic                         valid_o,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_o,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [CNT_WIDTH-1:0]         count_o
);
  // Narrow widths keep the low bits of the 64-bit default mask.
  localparam logic [DATA_WIDTH-1:0] DEF_POLY = DATA_WIDTH'(DEFAULT_POLY);

  typedef enum logic [2:0] {S_IDLE, S_SEED, S_RUN, S_DONE, S_BYP} state_t;

  state_t                             state;
  logic [DATA_WIDTH-1:0]              poly_q, stop_code_q;
  logic [CNT_WIDTH-1:0]               len_q, count_q, cnt_nxt;
  logic                               stop_en_q, byp_vld;
  logic [NUM_CH-1:0][DATA_WIDTH-1:0]  ch;
  logic                               run_xfer, byp_acc, last, ch_load;

  assign valid_o  = (state == S_RUN) | byp_vld;
  assign ready_o  = (state == S_BYP) & (~byp_vld | ready_i);
  assign busy_o   = (state == S_SEED) | (state == S_RUN);
  assign done_o   = (state == S_DONE);
  assign count_o  = count_q;
  assign data_o   = ch;

  assign run_xfer = (state == S_RUN) & ready_i;
  assign byp_acc  = ready_o & valid_i;
  assign ch_load  = (state == S_SEED) | byp_acc;
  assign cnt_nxt  = count_q + 1'b1;
  // Stop code is compared against the word leaving on this transfer.
  assign last     = ((len_q != '0) && (cnt_nxt == len_q)) ||
                    (stop_en_q && (ch[0] == stop_code_q));

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam int ROT = k % DATA_WIDTH;
    logic [DATA_WIDTH-1:0] rot_seed, seed_val, load_val;
    if (ROT == 0) begin : g_r0
      assign rot_seed = seed_i;
    end else begin : g_rn
      assign rot_seed = {seed_i[DATA_WIDTH-1-ROT:0], seed_i[DATA_WIDTH-1:DATA_WIDTH-ROT]};
    end
    // An all-zero Galois state is a lock-up, so it is replaced by 1.
    assign seed_val = (rot_seed == '0) ? DATA_WIDTH'(1) : rot_seed;
    assign load_val = (state == S_BYP) ? seed_i : seed_val;

    bist_prng_lane #(.W(DATA_WIDTH)) u_lane (
      .clk_i      (clk_i),
      .rstn_i     (rstn_i),
      .load_i     (ch_load),
      .load_val_i (load_val),
      .step_i     (run_xfer),
      .poly_i     (poly_q),
      .lfsr_o     (ch[k])
    );
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= S_IDLE;
      poly_q      <= '0;
      stop_code_q <= '0;
      len_q       <= '0;
      count_q     <= '0;
      stop_en_q   <= 1'b0;
      byp_vld     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bypass_i)     state <= S_BYP;
          else if (start_i) state <= S_SEED;
        end
        S_SEED: begin
          poly_q      <= (poly_i == '0) ? DEF_POLY : poly_i;
          len_q       <= length_i;
          stop_en_q   <= stop_en_i;
          stop_code_q <= stop_code_i;
          count_q     <= '0;
          state       <= S_RUN;
        end
        S_RUN: begin
          if (ready_i) begin
            count_q <= cnt_nxt;
            if (last) state <= S_DONE;
          end
        end
        S_DONE: begin
          if (bypass_i)     state <= S_IDLE;
          else if (start_i) state <= S_SEED;
        end
        S_BYP: begin
          // A word accepted on the exit cycle keeps us here until it drains.
          if (byp_acc)                    byp_vld <= 1'b1;
          else if (byp_vld && ready_i)    byp_vld <= 1'b0;
          if (!bypass_i && !byp_vld && !byp_acc) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/bist_prng_multi.md
BIST_PRNG_MULTI -- requirements
Module: bist_prng_multi

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64, bits per channel word.
REQ-002 SHALL have parameter NUM_CH, default 4, number of parallel LFSR channels (1..16).
REQ-003 SHALL have parameter CNT_WIDTH, default 16, width of the run-length counter.
REQ-004 SHALL have parameter DEFAULT_POLY, default 64'hD800_0000_0000_0000, Galois tap mask used when poly_i is zero.
REQ-005 SHALL have ports:
 clk_i  in  1  sole clock, rising edge
 rstn_i  in  1  asynchronous active-low reset
 start_i  in  1  launch a run (sampled in IDLE/DONE only)
 bypass_i  in  1  1 = external data passthrough (sampled in IDLE only)
 valid_i  in  1  bypass input valid
 ready_o  out  1  bypass input accepted when high
 seed_i  in  DATA_WIDTH  seed (run) or data (bypass)
 poly_i  in  DATA_WIDTH  Galois tap mask
 length_i  in  CNT_WIDTH  words per run; 0 = unbounded
 stop_en_i  in  1  enable stop-code termination
 stop_code_i  in  DATA_WIDTH  channel-0 terminating value
 ready_i  in  1  downstream ready
 valid_o  out  1  data_o valid
 data_o  out  NUM_CH*DATA_WIDTH  channel k at bits [k*DATA_WIDTH +: DATA_WIDTH]
 busy_o  out  1  FSM in SEED or RUN
 done_o  out  1  FSM in DONE
 count_o  out  CNT_WIDTH  completed transfers this run

Function
REQ-006 SHALL implement FSM states IDLE, SEED, RUN, DONE, BYP.
REQ-007 IDLE: start_i=1 and bypass_i=0 SHALL go to SEED; bypass_i=1 SHALL go to BYP; start_i has priority only when bypass_i=0.
REQ-008 SEED (one cycle): SHALL latch poly (DEFAULT_POLY if poly_i==0), length_i, stop_en_i, stop_code_i; SHALL load channel k with seed_i rotated left by k bits, or 1 if that value is 0; SHALL clear count_o; next state RUN.
REQ-009 RUN: valid_o SHALL be 1 and data_o SHALL equal the channel registers.
REQ-010 A transfer SHALL occur on a cycle with valid_o=1 and ready_i=1; only then SHALL each channel step and count_o increment.
REQ-011 Channel step SHALL be Galois right-shift: next = (s>>1) XOR (s[0] ? poly : 0).
REQ-012 While valid_o=1 and ready_i=0, data_o and count_o SHALL hold stable.
REQ-013 A transfer SHALL be the last of the run if count_o+1 equals a nonzero latched length, or if stop_en is latched 1 and channel-0 value being transferred equals the latched stop code; after the last transfer the state SHALL be DONE.
REQ-014 With latched length 0 and stop_en 0, RUN SHALL continue indefinitely and count_o SHALL wrap modulo 2^CNT_WIDTH.
REQ-015 start_i SHALL be ignored in SEED and RUN.
REQ-016 DONE: valid_o=0, done_o=1, count_o held; start_i=1 with bypass_i=0 SHALL go to SEED; bypass_i=1 SHALL go to IDLE.
REQ-017 BYP: ready_o SHALL be (valid_o=0 or ready_i=1); on valid_i and ready_o, every channel SHALL load seed_i and valid_o SHALL be 1 the next cycle; valid_o SHALL clear after a transfer with no new valid_i accepted that cycle; bypass_i=0 with valid_o=0 SHALL go to IDLE.
REQ-018 ready_o SHALL be 0 outside BYP.
REQ-019 busy_o SHALL be 1 exactly in SEED and RUN; done_o exactly in DONE.

Reset
REQ-020 rstn_i low SHALL immediately force IDLE, valid_o=0, done_o=0, busy_o=0, ready_o=0, count_o=0, data_o=0, regardless of state, including mid-run.
REQ-021 After reset release, first action SHALL require a new start_i or valid_i.

Verification (DATA_WIDTH=8, NUM_CH=2, poly_i=8'hB8)
REQ-022 seed 8'h01, length 3, ready_i=1 -> ch0 sequence 01,B8,5C and ch1 02,01,B8 on three consecutive valid_o cycles; done_o=1 next cycle, count_o=3.
REQ-023 same run with ready_i=0 for 4 cycles after first valid_o -> data_o held at {01,02}... i.e. ch0=01, ch1=02, count_o=0 until ready_i returns.
REQ-024 seed 8'h01, length 0, stop_en 1, stop_code 8'hB8 -> exactly two transfers (01, B8), then DONE, count_o=2.
REQ-025 seed 8'h00, poly_i 8'h00 -> ch0=ch1=8'h01 in RUN, stepping uses DEFAULT_POLY truncated to DATA_WIDTH.
REQ-026 bypass_i=1, valid_i with seed 8'hA5, ready_i=1 -> valid_o next cycle with data_o 16'hA5A5, then valid_o=0.
REQ-027 rstn_i pulsed low during RUN at count_o=2 -> outputs zero same cycle, IDLE after release, new start_i reproduces REQ-022 sequence.
